// File: rtl/ram_pkg.sv
// ram_pkg
// Shared constants and types for the unified instruction/data memory.
// Holds the geometry (ADDR_W, DATA_W, DEPTH), the word and address types,
// the boot/run state encoding and the boot program image that is loaded
// into the array whenever reset is asserted.
package ram_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Boot program: addi x1,x0,5 / addi x2,x0,3 / add x3,x1,x2 / sw x3,0(x0)
  localparam word_t INIT_IMAGE [DEPTH] = '{
    0:       32'h00500093,
    1:       32'h00300113,
    2:       32'h002081B3,
    3:       32'h00302023,
    default: 32'h00000000
  };

endpackage

// File: rtl/ram_fetch_ctrl.sv
// ram_fetch_ctrl
// Boot/run sequencer that produces the PC advance permission for the core.
// Ports:
//   clk            rising-edge clock
//   nRst           asynchronous reset, active low
//   write_enable_i DM write strobe; a write cycle stalls the PC one cycle
//   pc_enable_o    registered PC advance permission / instruction valid
module ram_fetch_ctrl
  import ram_pkg::*;
(
  input  logic clk,
  input  logic nRst,
  input  logic write_enable_i,
  output logic pc_enable_o
);

  state_e state_q, state_d;
  logic   pcEnable_q, pcEnable_d;
  logic   runOrLeaving;

  // State and permission registers; reset parks the sequencer in BOOT
  // with the PC held.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= BOOT;
      pcEnable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcEnable_q <= pcEnable_d;
    end
  end

  // BOOT is a single cycle so the first fetch after reset can settle
  // before the PC is allowed to move. Any DM write blocks the following
  // cycle's advance, so back-to-back writes give back-to-back stalls.
  always_comb begin
    state_d      = state_q;
    runOrLeaving = 1'b0;
    case (state_q)
      BOOT: begin
        state_d      = RUN;
        runOrLeaving = 1'b1;
      end
      RUN: begin
        state_d      = RUN;
        runOrLeaving = 1'b1;
      end
      default: begin
        state_d      = BOOT;
        runOrLeaving = 1'b0;
      end
    endcase
    pcEnable_d = runOrLeaving && (write_enable_i == 1'b1) == 1'b0;
  end

  assign pc_enable_o = pcEnable_q;

endmodule

// File: rtl/ram_unit.sv
// ram_unit
// Unified 32x32 memory for the single-cycle core: a registered instruction
// fetch port, a registered data read port and a synchronous data write
// port, preloaded with a boot image on reset.
// Ports:
//   clk          rising-edge clock
//   nRst         asynchronous reset, active low (reloads the boot image)
//   write_enable DM write strobe
//   read_enable  DM read strobe
//   address_DM   DM word address
//   address_IM   IM word address from the PC
//   data_in      DM write data
//   data_out     registered DM read data
//   instr_out    registered fetched instruction
//   pc_enable    PC advance permission / instruction valid
module ram_unit
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              nRst,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] address_DM,
  input  logic [ADDR_W-1:0] address_IM,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] instr_out,
  output logic              pc_enable
);

  word_t mem_q [DEPTH];
  word_t dataOut_q;
  word_t instrOut_q;

  // Array and both read registers. Reads sample mem_q before this edge's
  // write lands, which gives read-before-write on both ports for free.
  // The write is gated on a definite 1 so an unknown strobe never
  // touches the array.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INIT_IMAGE[i];
      end
      dataOut_q  <= '0;
      instrOut_q <= '0;
    end else begin
      instrOut_q <= mem_q[address_IM];
      if (read_enable == 1'b1) begin
        dataOut_q <= mem_q[address_DM];
      end
      if (write_enable == 1'b1) begin
        mem_q[address_DM] <= data_in;
      end
    end
  end

  ram_fetch_ctrl u_fetch_ctrl (
    .clk            (clk),
    .nRst           (nRst),
    .write_enable_i (write_enable),
    .pc_enable_o    (pc_enable)
  );

  assign data_out  = dataOut_q;
  assign instr_out = instrOut_q;

endmodule

// File: tb/tb_ram_unit.sv
// tb_ram_unit
// Directed bench for ram_unit. Inputs change on the falling edge, outputs
// are sampled 1 time unit after the rising edge. Expected values are
// written out by hand from the boot image and the stimulus.
module tb_ram_unit;

  logic        clk;
  logic        nRst;
  logic        write_enable;
  logic        read_enable;
  logic [4:0]  address_DM;
  logic [4:0]  address_IM;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] instr_out;
  logic        pc_enable;

  int checks;
  int failures;

  ram_unit dut (
    .clk          (clk),
    .nRst         (nRst),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .address_DM   (address_DM),
    .address_IM   (address_IM),
    .data_in      (data_in),
    .data_out     (data_out),
    .instr_out    (instr_out),
    .pc_enable    (pc_enable)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for the next rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs clear while reset is held; BOOT keeps pc_enable low until the
  // first edge after release, the BOOT fetch still loads word 0.
  task automatic test_reset();
    nRst = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    address_DM = '0; address_IM = '0; data_in = '0;
    tick(); tick();
    checks++; if (data_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_data_out got=%h exp=%h", data_out, 32'h0); end
    checks++; if (instr_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr_out got=%h exp=%h", instr_out, 32'h0); end
    checks++; if (pc_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_pc_enable got=%b exp=%b", pc_enable, 1'b0); end
    @(negedge clk); nRst = 1'b1; #1;
    checks++; if (pc_enable !== 1'b0) begin failures++; $display("[TB] FAIL boot_pc_enable got=%b exp=%b", pc_enable, 1'b0); end
    tick();
    checks++; if (pc_enable !== 1'b1) begin failures++; $display("[TB] FAIL run1_pc_enable got=%b exp=%b", pc_enable, 1'b1); end
    checks++; if (instr_out !== 32'h00500093) begin failures++; $display("[TB] FAIL boot_fetch got=%h exp=%h", instr_out, 32'h00500093); end
    tick();
    checks++; if (pc_enable !== 1'b1) begin failures++; $display("[TB] FAIL run2_pc_enable got=%b exp=%b", pc_enable, 1'b1); end
  endtask

  // Both ports walk words 0..3 of the boot image.
  task automatic test_read_image();
    logic [31:0] expWords [4];
    expWords[0] = 32'h00500093; expWords[1] = 32'h00300113;
    expWords[2] = 32'h002081B3; expWords[3] = 32'h00302023;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      read_enable = 1'b1; address_DM = 5'(i); address_IM = 5'(i);
      tick();
      checks++; if (data_out !== expWords[i]) begin failures++; $display("[TB] FAIL image_dm[%0d] got=%h exp=%h", i, data_out, expWords[i]); end
      checks++; if (instr_out !== expWords[i]) begin failures++; $display("[TB] FAIL image_im[%0d] got=%h exp=%h", i, instr_out, expWords[i]); end
    end
    @(negedge clk); read_enable = 1'b0;
  endtask

  // Single write stalls the PC one cycle, then both ports see the value.
  task automatic test_write_stall();
    @(negedge clk);
    write_enable = 1'b1; address_DM = 5'd5; data_in = 32'hDEADBEEF;
    tick();
    checks++; if (pc_enable !== 1'b0) begin failures++; $display("[TB] FAIL write_stall got=%b exp=%b", pc_enable, 1'b0); end
    @(negedge clk); write_enable = 1'b0;
    tick();
    checks++; if (pc_enable !== 1'b1) begin failures++; $display("[TB] FAIL write_resume got=%b exp=%b", pc_enable, 1'b1); end
    @(negedge clk); read_enable = 1'b1; address_DM = 5'd5; address_IM = 5'd5;
    tick();
    checks++; if (data_out !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL write_dm_read got=%h exp=%h", data_out, 32'hDEADBEEF); end
    checks++; if (instr_out !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL write_im_read got=%h exp=%h", instr_out, 32'hDEADBEEF); end
    @(negedge clk); read_enable = 1'b0;
  endtask

  // Two consecutive writes give two consecutive stalls; also exercises the
  // 31 -> 0 address wrap on the read port.
  task automatic test_back_to_back();
    @(negedge clk); write_enable = 1'b1; address_DM = 5'd6; data_in = 32'h66666666;
    tick();
    checks++; if (pc_enable !== 1'b0) begin failures++; $display("[TB] FAIL b2b_stall1 got=%b exp=%b", pc_enable, 1'b0); end
    @(negedge clk); address_DM = 5'd31; data_in = 32'hA5A5A5A5;
    tick();
    checks++; if (pc_enable !== 1'b0) begin failures++; $display("[TB] FAIL b2b_stall2 got=%b exp=%b", pc_enable, 1'b0); end
    @(negedge clk); write_enable = 1'b0; read_enable = 1'b1; address_DM = 5'd31;
    tick();
    checks++; if (pc_enable !== 1'b1) begin failures++; $display("[TB] FAIL b2b_resume got=%b exp=%b", pc_enable, 1'b1); end
    checks++; if (data_out !== 32'hA5A5A5A5) begin failures++; $display("[TB] FAIL addr31_read got=%h exp=%h", data_out, 32'hA5A5A5A5); end
    @(negedge clk); address_DM = 5'd0;
    tick();
    checks++; if (data_out !== 32'h00500093) begin failures++; $display("[TB] FAIL addr0_after31 got=%h exp=%h", data_out, 32'h00500093); end
    @(negedge clk); address_DM = 5'd6;
    tick();
    checks++; if (data_out !== 32'h66666666) begin failures++; $display("[TB] FAIL b2b_word6 got=%h exp=%h", data_out, 32'h66666666); end
    @(negedge clk); read_enable = 1'b0;
  endtask

  // Read and write together at the same address return the old word.
  task automatic test_read_before_write();
    @(negedge clk);
    read_enable = 1'b1; write_enable = 1'b1; address_DM = 5'd1; data_in = 32'h12345678;
    tick();
    checks++; if (data_out !== 32'h00300113) begin failures++; $display("[TB] FAIL rbw_old got=%h exp=%h", data_out, 32'h00300113); end
    @(negedge clk); write_enable = 1'b0;
    tick();
    checks++; if (data_out !== 32'h12345678) begin failures++; $display("[TB] FAIL rbw_new got=%h exp=%h", data_out, 32'h12345678); end
    @(negedge clk); read_enable = 1'b0;
  endtask

  // Fetching the address being written returns the old word first.
  task automatic test_im_collision();
    @(negedge clk);
    write_enable = 1'b1; address_DM = 5'd4; address_IM = 5'd4; data_in = 32'h11112222;
    tick();
    checks++; if (instr_out !== 32'h00000000) begin failures++; $display("[TB] FAIL im_coll_old got=%h exp=%h", instr_out, 32'h0); end
    @(negedge clk); write_enable = 1'b0;
    tick();
    checks++; if (instr_out !== 32'h11112222) begin failures++; $display("[TB] FAIL im_coll_new got=%h exp=%h", instr_out, 32'h11112222); end
  endtask

  // data_out holds while read_enable is low and the address moves.
  task automatic test_hold();
    @(negedge clk); read_enable = 1'b1; address_DM = 5'd3;
    tick();
    checks++; if (data_out !== 32'h00302023) begin failures++; $display("[TB] FAIL hold_load got=%h exp=%h", data_out, 32'h00302023); end
    @(negedge clk); read_enable = 1'b0; address_DM = 5'd0;
    tick();
    checks++; if (data_out !== 32'h00302023) begin failures++; $display("[TB] FAIL hold_a0 got=%h exp=%h", data_out, 32'h00302023); end
    @(negedge clk); address_DM = 5'd2;
    tick();
    checks++; if (data_out !== 32'h00302023) begin failures++; $display("[TB] FAIL hold_a2 got=%h exp=%h", data_out, 32'h00302023); end
  endtask

  // Write word 2, then reset mid-cycle: outputs clear at once and the
  // image comes back after release.
  task automatic test_reset_mid_write();
    @(negedge clk);
    write_enable = 1'b1; address_DM = 5'd2; data_in = 32'hCAFEF00D; address_IM = 5'd3;
    @(posedge clk); #2;
    nRst = 1'b0; #1;
    checks++; if (data_out !== 32'h0) begin failures++; $display("[TB] FAIL async_data_out got=%h exp=%h", data_out, 32'h0); end
    checks++; if (instr_out !== 32'h0) begin failures++; $display("[TB] FAIL async_instr_out got=%h exp=%h", instr_out, 32'h0); end
    checks++; if (pc_enable !== 1'b0) begin failures++; $display("[TB] FAIL async_pc_enable got=%b exp=%b", pc_enable, 1'b0); end
    write_enable = 1'b0;
    @(negedge clk); nRst = 1'b1;
    @(negedge clk); read_enable = 1'b1; address_DM = 5'd2; address_IM = 5'd2;
    tick();
    checks++; if (data_out !== 32'h002081B3) begin failures++; $display("[TB] FAIL restored_dm got=%h exp=%h", data_out, 32'h002081B3); end
    checks++; if (instr_out !== 32'h002081B3) begin failures++; $display("[TB] FAIL restored_im got=%h exp=%h", instr_out, 32'h002081B3); end
    @(negedge clk); address_DM = 5'd5;
    tick();
    checks++; if (data_out !== 32'h00000000) begin failures++; $display("[TB] FAIL restored_word5 got=%h exp=%h", data_out, 32'h0); end
    @(negedge clk); read_enable = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_read_image();
    test_write_stall();
    test_back_to_back();
    test_read_before_write();
    test_im_collision();
    test_hold();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_unit.md
Name: ram_unit

Overview:
- Unified 32-word x 32-bit memory shared by instruction fetch and data access in the single-cycle RISC core.
- Two independent registered read ports, one for instruction memory (IM) and one for data memory (DM), plus one synchronous write port on the DM side.
- A preload image, applied on reset, makes a boot program available without a loader.
- `pc_enable` tells the PC block when a fetched instruction is valid and the PC may advance.

Parameters:
- ADDR_W, 5, word-address width for both ports.
- DATA_W, 32, word width.
- DEPTH, 32, number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- nRst  input  1  asynchronous reset, active low.
- write_enable  input  1  DM write strobe, sampled at posedge.
- read_enable  input  1  DM read strobe, sampled at posedge.
- address_DM  input  ADDR_W  DM word address.
- address_IM  input  ADDR_W  IM word address (from PC).
- data_in  input  DATA_W  DM write data.
- data_out  output  DATA_W  registered DM read data.
- instr_out  output  DATA_W  registered fetched instruction.
- pc_enable  output  1  PC advance permission / instruction valid.

Behaviour:
- Clocking and reset:
  - One clock domain. All state changes on posedge clk.
  - nRst is asynchronous and active low; it takes effect immediately, independent of clk.
- Reset (nRst=0):
  - mem[i] <= INIT_IMAGE[i] for all i.
  - data_out=0, instr_out=0, pc_enable=0, FSM enters BOOT.
  - Reset asserted mid-write aborts the write; the image is restored.
- FSM has two states, BOOT and RUN:
  - BOOT: lasts exactly one cycle after nRst deasserts, pc_enable=0, then goes to RUN. The IM fetch still occurs in BOOT.
  - RUN: stays in RUN until reset.
- IM port:
  - Every posedge, instr_out <= mem[address_IM].
  - Latency is 1 cycle; there is no enable on this port.
- DM read:
  - At posedge with read_enable=1, data_out <= mem[address_DM].
  - With read_enable=0, data_out holds its value.
- DM write:
  - At posedge with write_enable=1, mem[address_DM] <= data_in.
- read_enable=1 and write_enable=1 together:
  - The write is performed.
  - data_out receives the old contents (read-before-write).
- IM fetch of an address being written in the same cycle:
  - instr_out gets the old contents; the new value is visible on the next fetch.
- pc_enable:
  - Registered output, value for the next cycle = (state==RUN or leaving BOOT) AND NOT write_enable.
  - A DM write cycle therefore stalls the PC for exactly one following cycle. Back-to-back writes stall for consecutive cycles.
- Addresses:
  - Addresses are word addresses with no byte lanes.
  - Full 5-bit range is valid; there is no out-of-range case.
  - Address 31 followed by 0 needs no special handling.
- X or undriven addresses must not corrupt memory: a write occurs only when write_enable==1'b1.

Decomposition:
- Package ram_pkg holds:
  - ADDR_W, DATA_W, DEPTH constants.
  - Word typedef (logic [DATA_W-1:0]) and address typedef.
  - State enum {BOOT, RUN}.
  - INIT_IMAGE constant array:
    - word0=32'h00500093
    - word1=32'h00300113
    - word2=32'h002081B3
    - word3=32'h00302023
    - words 4..31=0.
- No sub-module is required. Optionally factor out the pc_enable/BOOT FSM as ram_fetch_ctrl.

Test Plan:
- Reset, then release; hold write_enable=0 -> cycle 1 after release pc_enable=0, from cycle 2 pc_enable=1. All outputs are 0 during reset.
- read_enable=1; drive address_IM=address_DM=0,1,2,3 on successive cycles:
  - instr_out and data_out each show 00500093, 00300113, 002081B3, 00302023 one cycle after their address.
- write_enable=1, address_DM=5, data_in=32'hDEADBEEF for one cycle:
  - pc_enable=0 the next cycle.
  - Later read_enable=1 at address 5 gives data_out=DEADBEEF.
  - address_IM=5 gives instr_out=DEADBEEF.
- Simultaneous read and write at address 1 with data_in=32'h12345678:
  - data_out=00300113 (old value).
  - A following read gives 12345678.
- Write to address 2 (data_in=32'hCAFEF00D), then assert nRst=0 asynchronously mid-cycle:
  - Outputs clear immediately.
  - After release, reading address 2 gives 002081B3 (image restored).
- read_enable=0 while address_DM changes -> data_out holds its previous value.
